// File: rtl/agex_branch_resolver.sv
// Execute-stage branch resolver: computes branch outcome, redirects fetch on mispredict,
// and queues predictor training records. Optional statistics counters under BR_STATS_EN.
module agex_branch_resolver #(
   parameter int unsigned DBITS         = 32,
   parameter int unsigned BPBITS        = 8,
   parameter int unsigned UPD_DEPTH     = 4,
   parameter int unsigned SQUASH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              br_valid,
   input  logic [2:0]        br_op,
   input  logic [DBITS-1:0]  br_pc,
   input  logic [DBITS-1:0]  br_rs1,
   input  logic [DBITS-1:0]  br_rs2,
   input  logic [DBITS-1:0]  br_imm,
   input  logic [BPBITS-1:0] br_pht_idx,
   input  logic [DBITS-1:0]  br_pred_target,
   output logic              stall_out,
   output logic              redirect_valid,
   output logic [DBITS-1:0]  redirect_pc,
   output logic              branch_invalid,
   output logic              upd_valid,
   input  logic              upd_ready,
   output logic              upd_dir,
   output logic [BPBITS-1:0] upd_pht_idx,
   output logic [DBITS-1:0]  upd_target,
   output logic [DBITS-1:0]  upd_pc,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispred
);

   localparam int unsigned PW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
   localparam int unsigned CW = $clog2(UPD_DEPTH + 1);
   localparam int unsigned SW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

   typedef enum logic {S_IDLE, S_SQUASH} state_t;

   typedef struct packed {
      logic              dir;
      logic [BPBITS-1:0] idx;
      logic [DBITS-1:0]  target;
      logic [DBITS-1:0]  pc;
   } upd_rec_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     sq_cnt_q, sq_cnt_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [DBITS-1:0]  redirect_pc_q, redirect_pc_d;
   logic              branch_invalid_q, branch_invalid_d;
   upd_rec_t          mem_q [UPD_DEPTH];
   upd_rec_t          mem_d [UPD_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic              taken, is_cond, full, pop, push, idle, accept, mispred;
   logic [DBITS-1:0]  target, actual_next;

   always_comb begin
      taken = 1'b1;
      case (br_op)
         3'd0:    taken = (br_rs1 == br_rs2);
         3'd1:    taken = (br_rs1 != br_rs2);
         3'd2:    taken = ($signed(br_rs1) <  $signed(br_rs2));
         3'd3:    taken = ($signed(br_rs1) >= $signed(br_rs2));
         3'd4:    taken = (br_rs1 <  br_rs2);
         3'd5:    taken = (br_rs1 >= br_rs2);
         default: taken = 1'b1;
      endcase
      target      = (br_op == 3'd7) ? ((br_rs1 + br_imm) & ~DBITS'(1)) : (br_pc + br_imm);
      actual_next = taken ? target : (br_pc + DBITS'(4));
      is_cond     = (br_op < 3'd6);
   end

   assign full      = (count_q == CW'(UPD_DEPTH));
   assign upd_valid = (count_q != '0);
   assign pop       = upd_valid && upd_ready;
   assign idle      = (state_q == S_IDLE);
   // A full queue still accepts when the head drains in the same cycle.
   assign accept    = br_valid && idle && !(full && !pop);
   assign stall_out = br_valid && idle && full && !pop;
   assign mispred   = accept && (actual_next != br_pred_target);
   assign push      = accept && is_cond;

   always_comb begin
      state_d  = state_q;
      sq_cnt_d = sq_cnt_q;
      case (state_q)
         S_IDLE:
            if (mispred) begin
               state_d  = S_SQUASH;
               sq_cnt_d = SW'(SQUASH_CYCLES - 1);
            end
         S_SQUASH:
            if (sq_cnt_q == '0) state_d = S_IDLE;
            else                sq_cnt_d = sq_cnt_q - SW'(1);
         default: state_d = S_IDLE;
      endcase
      redirect_valid_d = mispred;
      redirect_pc_d    = mispred ? actual_next : redirect_pc_q;
      branch_invalid_d = (state_d == S_SQUASH);
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{dir: taken, idx: br_pht_idx, target: target, pc: br_pc};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         sq_cnt_q         <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         branch_invalid_q <= 1'b0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         for (int unsigned i = 0; i < UPD_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q          <= state_d;
         sq_cnt_q         <= sq_cnt_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         branch_invalid_q <= branch_invalid_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         mem_q            <= mem_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign branch_invalid = branch_invalid_q;
   assign upd_dir        = mem_q[rd_ptr_q].dir;
   assign upd_pht_idx    = mem_q[rd_ptr_q].idx;
   assign upd_target     = mem_q[rd_ptr_q].target;
   assign upd_pc         = mem_q[rd_ptr_q].pc;

`ifdef BR_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d, stat_mispred_q, stat_mispred_d;

   always_comb begin
      stat_branches_d = stat_branches_q;
      stat_mispred_d  = stat_mispred_q;
      if (accept  && (stat_branches_q != '1)) stat_branches_d = stat_branches_q + 32'd1;
      if (mispred && (stat_mispred_q  != '1)) stat_mispred_d  = stat_mispred_q  + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_branches_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         stat_branches_q <= stat_branches_d;
         stat_mispred_q  <= stat_mispred_d;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_mispred  = stat_mispred_q;
`else
   assign stat_branches = '0;
   assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_agex_branch_resolver.sv
// Self-checking bench for agex_branch_resolver: vector table plus a training-record scoreboard.
module tb_agex_branch_resolver;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        br_valid = 1'b0;
   logic [2:0]  br_op = '0;
   logic [31:0] br_pc = '0, br_rs1 = '0, br_rs2 = '0, br_imm = '0, br_pred_target = '0;
   logic [7:0]  br_pht_idx = '0;
   logic        stall_out, redirect_valid, branch_invalid, upd_valid, upd_dir;
   logic        upd_ready = 1'b1;
   logic [31:0] redirect_pc, upd_target, upd_pc, stat_branches, stat_mispred;
   logic [7:0]  upd_pht_idx;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] pc, rs1, rs2, imm, pred;
      logic [7:0]  idx;
      logic        exp_dir;
      logic [31:0] exp_tgt;
      logic        exp_mis;
      logic [31:0] exp_next;
   } vec_t;

   typedef struct {
      logic        dir;
      logic [7:0]  idx;
      logic [31:0] target, pc;
   } rec_t;

   rec_t        sb[$];
   int          total = 0, bad = 0;
   int unsigned exp_br = 0, exp_mp = 0;
   vec_t        tbl [9];

   agex_branch_resolver #(
      .DBITS(32), .BPBITS(8), .UPD_DEPTH(4), .SQUASH_CYCLES(S)
   ) dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op), .br_pc(br_pc),
      .br_rs1(br_rs1), .br_rs2(br_rs2), .br_imm(br_imm), .br_pht_idx(br_pht_idx),
      .br_pred_target(br_pred_target), .stall_out(stall_out),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .branch_invalid(branch_invalid), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_dir(upd_dir), .upd_pht_idx(upd_pht_idx), .upd_target(upd_target),
      .upd_pc(upd_pc), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] pc, rs1, rs2, imm,
                               pred, input logic [7:0] idx, input logic dir,
                               input logic [31:0] tgt, input logic mis,
                               input logic [31:0] nxt);
      vec_t v;
      v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pred = pred;
      v.idx = idx; v.exp_dir = dir; v.exp_tgt = tgt; v.exp_mis = mis; v.exp_next = nxt;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      br_op = v.op; br_pc = v.pc; br_rs1 = v.rs1; br_rs2 = v.rs2; br_imm = v.imm;
      br_pred_target = v.pred; br_pht_idx = v.idx; br_valid = 1'b1;
   endtask

   task automatic note_accept(input vec_t v);
      if (v.op < 3'd6) sb.push_back('{v.exp_dir, v.idx, v.exp_tgt, v.pc});
      exp_br++;
      if (v.exp_mis) exp_mp++;
   endtask

   // Called at posedge+1; returns at posedge+1 once the resolver is idle again.
   task automatic issue(input vec_t v);
      vec_t wp;
      wp = mk(3'd0, 32'h900, 32'd0, 32'd0, 32'h10, 32'h0, 8'hEE, 1'b1, 32'h910, 1'b1, 32'h910);
      drive(v);
      @(negedge clk);
      chk("stall_out_accept", stall_out, 0);
      note_accept(v);
      @(posedge clk); #1;
      br_valid = 1'b0;
      if (v.exp_mis) begin
         drive(wp);
         for (int k = 0; k < S; k++) begin
            @(negedge clk);
            chk("branch_invalid_sq", branch_invalid, 1);
            chk("stall_out_sq", stall_out, 0);
            chk("redirect_valid_sq", redirect_valid, (k == 0) ? 1 : 0);
            if (k == 0) chk("redirect_pc", redirect_pc, v.exp_next);
            if (k == 0 && v.op < 3'd6) chk("upd_valid_after_push", upd_valid, 1);
            @(posedge clk); #1;
         end
         br_valid = 1'b0;
      end else begin
         @(negedge clk);
         chk("redirect_valid_none", redirect_valid, 0);
         if (v.op < 3'd6) chk("upd_valid_after_push", upd_valid, 1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("branch_invalid_end", branch_invalid, 0);
      chk("redirect_valid_end", redirect_valid, 0);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
      #1;
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic chk_stats(input string tag);
`ifdef BR_STATS_EN
      chk({tag, "_stat_branches"}, stat_branches, exp_br);
      chk({tag, "_stat_mispred"}, stat_mispred, exp_mp);
`else
      chk({tag, "_stat_branches"}, stat_branches, 0);
      chk({tag, "_stat_mispred"}, stat_mispred, 0);
`endif
   endtask

   always @(negedge clk) begin
      if (reset && upd_valid && upd_ready) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_extra: got record pc 0x%0h expected none", upd_pc);
         end else begin
            rec_t e;
            e = sb.pop_front();
            chk("upd_dir", upd_dir, e.dir);
            chk("upd_pht_idx", upd_pht_idx, e.idx);
            chk("upd_target", upd_target, e.target);
            chk("upd_pc", upd_pc, e.pc);
         end
      end
   end

   initial begin
      vec_t qv;
      tbl[0] = mk(3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 32'h120, 8'h01, 1'b1, 32'h120, 1'b0, 32'h0);
      tbl[1] = mk(3'd1, 32'h200, 32'd7, 32'd7, 32'h40, 32'h240, 8'h02, 1'b0, 32'h240, 1'b1, 32'h204);
      tbl[2] = mk(3'd7, 32'h300, 32'h1001, 32'd0, 32'd4, 32'h0, 8'h03, 1'b1, 32'h1004, 1'b1, 32'h1004);
      tbl[3] = mk(3'd2, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h410, 8'h04, 1'b1, 32'h410, 1'b0, 32'h0);
      tbl[4] = mk(3'd4, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h504, 8'h05, 1'b0, 32'h510, 1'b0, 32'h0);
      tbl[5] = mk(3'd3, 32'h600, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'h604, 8'h06, 1'b1, 32'h5F0, 1'b1, 32'h5F0);
      tbl[6] = mk(3'd5, 32'h700, 32'd3, 32'hFFFF_FFFE, 32'd8, 32'h704, 8'h07, 1'b0, 32'h708, 1'b0, 32'h0);
      tbl[7] = mk(3'd6, 32'hFFFF_FFF8, 32'd0, 32'd0, 32'h10, 32'h8, 8'h08, 1'b1, 32'h8, 1'b0, 32'h0);
      tbl[8] = mk(3'd0, 32'h800, 32'd1, 32'd2, 32'h20, 32'h820, 8'h09, 1'b0, 32'h820, 1'b1, 32'h804);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_branch_invalid", branch_invalid, 0);
      chk("rst_upd_valid", upd_valid, 0);
      chk("rst_upd_pc", upd_pc, 0);
      chk_stats("rst");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) issue(tbl[i]);
      drain();
      chk_stats("table");

      // Queue fill: four records held, fifth stalls until the head drains.
      upd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         qv = mk(3'd0, 32'hA00 + 32'(i) * 32'h10, 32'(i), 32'(i), 32'd8,
                 32'hA08 + 32'(i) * 32'h10, 8'h40 + 8'(i), 1'b1,
                 32'hA08 + 32'(i) * 32'h10, 1'b0, 32'h0);
         issue(qv);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("head_hold_valid", upd_valid, 1);
         chk("head_hold_pc", upd_pc, 32'hA00);
      end
      @(posedge clk); #1;
      qv = mk(3'd1, 32'hA40, 32'd1, 32'd2, 32'd8, 32'hA48, 8'h44, 1'b1, 32'hA48, 1'b0, 32'h0);
      drive(qv);
      @(negedge clk);
      chk("stall_full", stall_out, 1);
      @(posedge clk); #1;
      upd_ready = 1'b1;
      @(negedge clk);
      chk("stall_full_pop", stall_out, 0);
      note_accept(qv);
      @(posedge clk); #1;
      br_valid = 1'b0;
      drain();
      chk_stats("full");

      // Reset while squashing with three records queued.
      upd_ready = 1'b0;
      issue(mk(3'd0, 32'hB00, 32'd9, 32'd9, 32'h8, 32'hB08, 8'h50, 1'b1, 32'hB08, 1'b0, 32'h0));
      issue(mk(3'd0, 32'hB10, 32'd9, 32'd9, 32'h8, 32'hB18, 8'h51, 1'b1, 32'hB18, 1'b0, 32'h0));
      qv = mk(3'd1, 32'hB20, 32'd3, 32'd3, 32'h40, 32'hB60, 8'h52, 1'b0, 32'hB60, 1'b1, 32'hB24);
      drive(qv);
      @(negedge clk);
      note_accept(qv);
      @(posedge clk); #1;
      br_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_branch_invalid", branch_invalid, 1);
      chk("pre_rst_upd_valid", upd_valid, 1);
      #1;
      reset = 1'b0;
      #1;
      sb.delete();
      exp_br = 0;
      exp_mp = 0;
      chk("mid_rst_redirect_valid", redirect_valid, 0);
      chk("mid_rst_redirect_pc", redirect_pc, 0);
      chk("mid_rst_branch_invalid", branch_invalid, 0);
      chk("mid_rst_upd_valid", upd_valid, 0);
      chk("mid_rst_upd_dir", upd_dir, 0);
      chk("mid_rst_upd_pht_idx", upd_pht_idx, 0);
      chk("mid_rst_upd_target", upd_target, 0);
      chk("mid_rst_upd_pc", upd_pc, 0);
      chk_stats("mid_rst");
      @(posedge clk); #1;
      reset = 1'b1;
      upd_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_upd_valid", upd_valid, 0);
      chk("post_rst_branch_invalid", branch_invalid, 0);
      @(posedge clk); #1;
      issue(tbl[0]);
      drain();
      chk_stats("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
